// File: rtl/jtframe_mix_pkg.sv
// Shared definitions for the sequential mixer: FSM encoding and gain fixed-point format.
package jtframe_mix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] GAIN_UNITY = 8'h10;
  localparam int         GAIN_FRAC  = 4;

endpackage

// File: rtl/jtframe_mixsat.sv
// Drops the gain fractional bits from the accumulator and clamps the result to OW bits.
module jtframe_mixsat
  import jtframe_mix_pkg::*;
#(
  parameter int AW = 18,
  parameter int OW = 10
) (
  input  logic [AW-1:0] acc,
  output logic [OW-1:0] res
);

  localparam int SW = AW - GAIN_FRAC;

  logic [SW-1:0] shifted;
  logic          unused_frac;

  assign shifted     = acc[AW-1:GAIN_FRAC];
  assign unused_frac = ^acc[GAIN_FRAC-1:0];

  generate
    if (SW > OW) begin : g_sat
      assign res = (|shifted[SW-1:OW]) ? {OW{1'b1}} : shifted[OW-1:0];
    end else begin : g_pass
      assign res = OW'(shifted);
    end
  endgenerate

endmodule

// File: rtl/jtframe_mixseq.sv
// Sequential CH-channel gain mixer sharing one multiplier, saturating output.
// Optional peak hold enabled by defining JTFRAME_MIX_PEAK_EN.
module jtframe_mixseq
  import jtframe_mix_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = 8,
  parameter int GW = 8,
  parameter int OW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            sample_in,
  input  logic [CH*W-1:0] din,
  input  logic [CH*GW-1:0] gain,
  output logic [OW-1:0]   dout,
  output logic            sample,
  output logic            busy,
  output logic            overrun,
  output logic [OW-1:0]   peak,
  input  logic            peak_clr
);

  // Wide enough that CH full-scale products can never overflow
  localparam int AW = W + GW + $clog2(CH);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW = W + GW;

  state_t           st;
  logic [CH*W-1:0]  din_snap;
  logic [CH*GW-1:0] gain_snap;
  logic [CW-1:0]    ch;
  logic [AW-1:0]    acc;
  logic [PW-1:0]    prod;
  logic [OW-1:0]    res;
  logic [W-1:0]     din_arr  [CH];
  logic [GW-1:0]    gain_arr [CH];

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      assign din_arr[gi]  = din_snap[gi*W +: W];
      assign gain_arr[gi] = gain_snap[gi*GW +: GW];
    end
  endgenerate

  assign prod = PW'(din_arr[ch]) * PW'(gain_arr[ch]);

  jtframe_mixsat #(.AW(AW), .OW(OW)) u_sat (
    .acc (acc),
    .res (res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      din_snap  <= '0;
      gain_snap <= '0;
      ch        <= '0;
      acc       <= '0;
      dout      <= '0;
      sample    <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (cen) begin
        case (st)
          IDLE: if (sample_in) begin
            din_snap  <= din;
            gain_snap <= gain;
            acc       <= '0;
            ch        <= '0;
            busy      <= 1'b1;
            st        <= MIX;
          end
          MIX: begin
            acc <= acc + AW'(prod);
            if (ch == CW'(CH-1)) st <= DONE;
            else                 ch <= ch + 1'b1;
          end
          DONE: begin
            dout   <= res;
            sample <= 1'b1;
            busy   <= 1'b0;
            st     <= IDLE;
          end
          default: st <= IDLE;
        endcase
        // Requests during a round, including its final DONE cycle, are dropped
        if (sample_in && st != IDLE) overrun <= 1'b1;
      end
    end
  end

`ifdef JTFRAME_MIX_PEAK_EN
  always_ff @(posedge clk) begin
    if (rst || peak_clr)                   peak <= '0;
    else if (cen && st == DONE && res > peak) peak <= res;
  end
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak = '0;
`endif

endmodule

// File: tb/tb_jtframe_mixseq.sv
// Directed self-checking bench for jtframe_mixseq (default parameters).
// Peak expectations follow JTFRAME_MIX_PEAK_EN when it is defined for the build.
module tb_jtframe_mixseq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b1;
  logic        sample_in = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] gain = '0;
  logic [9:0]  dout;
  logic        sample, busy, overrun;
  logic [9:0]  peak;
  logic        peak_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  jtframe_mixseq #(.CH(4), .W(8), .GW(8), .OW(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .sample_in (sample_in),
    .din       (din),
    .gain      (gain),
    .dout      (dout),
    .sample    (sample),
    .busy      (busy),
    .overrun   (overrun),
    .peak      (peak),
    .peak_clr  (peak_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_in = 1'b0; cen = 1'b1; peak_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // One round with cen asserted every 'period' clocks; inputs are scrambled after acceptance.
  task automatic do_round(input logic [31:0] d, input logic [31:0] g, input int period,
                          output int lat, output int pulses, output logic [9:0] val,
                          output logic busy_seen);
    int cen_cnt = 0;
    int ph = 0;
    int tail = -1;
    lat = -1; pulses = 0; val = 'x; busy_seen = 1'b0;
    din = d; gain = g; sample_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cen = (ph == 0);
      ph = (ph + 1) % period;
      if (cen) cen_cnt++;
      tick();
      if (cen && cen_cnt == 1) begin
        busy_seen = busy;
        sample_in = 1'b0;
        din = ~d; gain = ~g;
      end
      if (sample) begin
        pulses++;
        if (lat < 0) begin lat = cen_cnt; val = dout; tail = 2*period + 2; end
      end
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    cen = 1'b1;
    $display("round din=%08h gain=%08h cen1of%0d lat=%0d pulses=%0d dout=%0d",
             d, g, period, lat, pulses, val);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dout !== 10'd0)  begin errors++; $display("FAIL reset_dout got=%0d want=0", dout); end
    checks++; if (sample !== 1'b0) begin errors++; $display("FAIL reset_sample got=%b want=0", sample); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    checks++; if (peak !== 10'd0)  begin errors++; $display("FAIL reset_peak got=%0d want=0", peak); end
  endtask

  task automatic test_basic();
    int lat, pulses; logic [9:0] val; logic bs;
    do_round({8'd40, 8'd30, 8'd20, 8'd10}, {4{8'h10}}, 1, lat, pulses, val, bs);
    checks++; if (bs !== 1'b1)     begin errors++; $display("FAIL basic_busy got=%b want=1", bs); end
    checks++; if (lat !== 6)       begin errors++; $display("FAIL basic_latency got=%0d want=6", lat); end
    checks++; if (val !== 10'd100) begin errors++; $display("FAIL basic_dout got=%0d want=100", val); end
    checks++; if (pulses !== 1)    begin errors++; $display("FAIL basic_pulses got=%0d want=1", pulses); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL basic_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_gains();
    int lat, pulses; logic [9:0] val; logic bs;
    // 255*255*4 >> 4 = 16256, clamps to 1023
    do_round({4{8'd255}}, {4{8'hFF}}, 1, lat, pulses, val, bs);
    checks++; if (val !== 10'd1023) begin errors++; $display("FAIL sat_dout got=%0d want=1023", val); end
    // 100*8 + 50*32 + 200*0 + 0*255 = 2400 >> 4 = 150
    do_round({8'd0, 8'd200, 8'd50, 8'd100}, {8'hFF, 8'h00, 8'h20, 8'h08}, 1, lat, pulses, val, bs);
    checks++; if (val !== 10'd150) begin errors++; $display("FAIL mixed_dout got=%0d want=150", val); end
    // 4*5*3 = 60 >> 4 = 3 (fraction truncated)
    do_round({4{8'd5}}, {4{8'h03}}, 1, lat, pulses, val, bs);
    checks++; if (val !== 10'd3) begin errors++; $display("FAIL trunc_dout got=%0d want=3", val); end
    do_round({8'd99, 8'd77, 8'd55, 8'd33}, 32'h0, 1, lat, pulses, val, bs);
    checks++; if (val !== 10'd0) begin errors++; $display("FAIL mute_dout got=%0d want=0", val); end
    checks++; if (pulses !== 1)  begin errors++; $display("FAIL mute_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_cen();
    int lat, pulses; logic [9:0] val; logic bs;
    do_round({8'd40, 8'd30, 8'd20, 8'd10}, {4{8'h10}}, 3, lat, pulses, val, bs);
    checks++; if (lat !== 6)       begin errors++; $display("FAIL cen_latency got=%0d want=6", lat); end
    checks++; if (pulses !== 1)    begin errors++; $display("FAIL cen_pulse_width got=%0d want=1", pulses); end
    checks++; if (val !== 10'd100) begin errors++; $display("FAIL cen_dout got=%0d want=100", val); end
  endtask

  // Second request lands on edge k of the round (3 = MIX, 6 = DONE)
  task automatic test_overrun();
    int ks[2] = '{3, 6};
    foreach (ks[j]) begin
      int pulses = 0;
      do_reset();
      din = {8'd40, 8'd30, 8'd20, 8'd10}; gain = {4{8'h10}};
      for (int e = 1; e <= 16; e++) begin
        sample_in = (e == 1 || e == ks[j]);
        tick();
        if (e == 1) begin din = {4{8'd255}}; gain = {4{8'hFF}}; end
        if (sample) pulses++;
      end
      sample_in = 1'b0;
      $display("overrun k=%0d pulses=%0d dout=%0d overrun=%b", ks[j], pulses, dout, overrun);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag k=%0d got=%b want=1", ks[j], overrun); end
      checks++; if (pulses !== 1)     begin errors++; $display("FAIL overrun_pulses k=%0d got=%0d want=1", ks[j], pulses); end
      checks++; if (dout !== 10'd100) begin errors++; $display("FAIL overrun_dout k=%0d got=%0d want=100", ks[j], dout); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL overrun_busy k=%0d got=%b want=0", ks[j], busy); end
      for (int e = 0; e < 5; e++) tick();
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky k=%0d got=%b want=1", ks[j], overrun); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, pulses, stray; logic [9:0] val; logic bs;
    stray = 0;
    din = {4{8'd100}}; gain = {4{8'h10}}; sample_in = 1'b1;
    tick(); sample_in = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if (dout !== 10'd0)   begin errors++; $display("FAIL rstmid_dout got=%0d want=0", dout); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got=%b want=0", overrun); end
    for (int e = 0; e < 10; e++) begin tick(); if (sample) stray++; end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_pulse got=%0d want=0", stray); end
    do_round({8'd40, 8'd30, 8'd20, 8'd10}, {4{8'h10}}, 1, lat, pulses, val, bs);
    checks++; if (val !== 10'd100) begin errors++; $display("FAIL rstmid_next_dout got=%0d want=100", val); end
  endtask

  task automatic test_peak();
    int lat, pulses; logic [9:0] val; logic bs;
    logic [9:0] exp_peak [4];
`ifdef JTFRAME_MIX_PEAK_EN
    exp_peak = '{10'd300, 10'd800, 10'd800, 10'd200};
`else
    exp_peak = '{10'd0, 10'd0, 10'd0, 10'd0};
`endif
    do_reset();
    do_round({4{8'd75}}, {4{8'h10}}, 1, lat, pulses, val, bs);
    checks++; if (peak !== exp_peak[0]) begin errors++; $display("FAIL peak_300 got=%0d want=%0d", peak, exp_peak[0]); end
    do_round({4{8'd200}}, {4{8'h10}}, 1, lat, pulses, val, bs);
    checks++; if (peak !== exp_peak[1]) begin errors++; $display("FAIL peak_800 got=%0d want=%0d", peak, exp_peak[1]); end
    do_round({4{8'd125}}, {4{8'h10}}, 1, lat, pulses, val, bs);
    checks++; if (peak !== exp_peak[2]) begin errors++; $display("FAIL peak_500 got=%0d want=%0d", peak, exp_peak[2]); end
    peak_clr = 1'b1; tick(); peak_clr = 1'b0;
    checks++; if (peak !== 10'd0) begin errors++; $display("FAIL peak_clr got=%0d want=0", peak); end
    do_round({4{8'd50}}, {4{8'h10}}, 1, lat, pulses, val, bs);
    checks++; if (peak !== exp_peak[3]) begin errors++; $display("FAIL peak_200 got=%0d want=%0d", peak, exp_peak[3]); end
    checks++; if (val !== 10'd200) begin errors++; $display("FAIL peak_round_dout got=%0d want=200", val); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gains();
    test_cen();
    test_overrun();
    test_reset_mid();
    test_peak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
